// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction-fetch slice of the pipeline.
package pipe_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  localparam logic [4:0] OPC_HALT = 5'b11111;

  // Instruction field bit positions (imm and address overlap the register fields)
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int WREG_HI = 26;
  localparam int WREG_LO = 22;
  localparam int REGA_HI = 21;
  localparam int REGA_LO = 17;
  localparam int REGB_HI = 16;
  localparam int REGB_LO = 12;
  localparam int IMM_HI  = 16;
  localparam int IMM_LO  = 0;
  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_HALT
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] word);
    return word[OPC_HI:OPC_LO] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, instruction} entries.
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero when empty so stale entries never leak downstream
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipe_if_fetch.sv
// Instruction fetch stage: PC, memory req/ack FSM, redirect squash and output FIFO.
// Optional HALT-opcode stop is enabled with `define FETCH_HALT_DETECT_EN.
module pipe_if_fetch
  import pipe_pkg::*;
#(
  parameter int              ADDR_W     = ADDR_W_DEF,
  parameter int              DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] InstructionOUT,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W  = CNT_W + 1;

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic              drop, drop_next;
  logic              push, pop, outstanding, credit_ok;
  logic [CRED_W-1:0] credit_used;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  assign outstanding = (state == F_WAIT);
  assign credit_used = {1'b0, fifo_count} + CRED_W'(outstanding);
  assign credit_ok   = credit_used < CRED_W'(FIFO_DEPTH);
  assign pop         = instr_valid & instr_ready & ~redirect;

  assign mem_req        = outstanding;
  assign mem_addr       = addr_q;
  assign instr_valid    = ~fifo_empty;
  assign InstructionOUT = head[DATA_W-1:0];
  assign instr_pc       = head[ENTRY_W-1 -: ADDR_W];

  always_comb begin
    state_next = state;
    pc_next    = pc;
    addr_next  = addr_q;
    drop_next  = drop;
    push       = 1'b0;
    case (state)
      F_IDLE: begin
        if (redirect) begin
          pc_next = redirect_pc;
        end else if (credit_ok && !fifo_full) begin
          addr_next  = pc;
          state_next = F_WAIT;
        end
      end
      F_WAIT: begin
        if (mem_ack) begin
          state_next = F_IDLE;
          drop_next  = 1'b0;
          if (redirect) begin
            pc_next = redirect_pc;
          end else if (!drop) begin
            push    = 1'b1;
            pc_next = pc + 1'b1;
`ifdef FETCH_HALT_DETECT_EN
            if (is_halt(mem_rdata)) state_next = F_HALT;
`endif
          end
        end else if (redirect) begin
          // Request stays on the bus; its data will be discarded when it returns
          pc_next   = redirect_pc;
          drop_next = 1'b1;
        end
      end
      F_HALT: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = F_IDLE;
        end
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= F_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      drop   <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      addr_q <= addr_next;
      drop   <= drop_next;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({addr_q, mem_rdata}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Self-checking bench for pipe_if_fetch: randomized memory latency, stalls and
// redirects checked against a stream-level model of the fetched instruction sequence.
module tb_pipe_if_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [31:0] InstructionOUT;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  int cyc = 0, lat_min = 0, lat_max = 0, lat = 0, buffered = 0, last_req_cyc = -1;
  bit busy = 0, tainted = 0, model_ok = 0, halted = 0;
  bit new_req_seen = 0, fired = 0, check_gap = 0, hold_armed = 0;
  logic [15:0] req_addr = '0, exp_req = '0, exp_out = '0, hold_pc = '0, last_xfer_pc = '0;
  logic [31:0] hold_word = '0;

  always #5 clk = ~clk;

  pipe_if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .InstructionOUT (InstructionOUT),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  // Memory image; bit 27 cleared so only the planted word can look like HALT
  function automatic logic [31:0] img(input logic [15:0] a);
    logic [31:0] w;
    w = ({16'h0, a} * 32'h0001_0193) ^ 32'h5A5A_1234;
    w[27] = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    if (a == 16'd5) w = 32'hF800_0000;
`endif
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample at negedge, check, drive inputs for the next posedge, advance model.
  // redir_mode: 0 none, 1 always, 2 only with ack and valid (forces ready), 3 only while waiting.
  task automatic applyStimulus(input bit do_rst, input bit rdy, input int redir_mode,
                               input logic [15:0] tgt, input bit late_ack);
    bit ack_now, fire, xfer;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    new_req_seen = 0;
    ack_now = 0;
    fire = 0;
    if (model_ok && hold_armed) begin
      checkOutput("hold_valid", instr_valid, 1);
      checkOutput("hold_pc", instr_pc, hold_pc);
      checkOutput("hold_word", InstructionOUT, hold_word);
    end
    if (model_ok) checkOutput("valid", instr_valid, buffered > 0);
    if (busy && !mem_req) begin
      checkOutput("req_held", mem_req, 1);
      busy = 0;
    end
    if (mem_req && !busy) begin
      busy = 1;
      req_addr = mem_addr;
      lat = int'($urandom_range(lat_max, lat_min));
      new_req_seen = 1;
      if (model_ok) begin
        checkOutput("req_addr", mem_addr, exp_req);
        checkOutput("credit", buffered < DEPTH, 1);
        if (check_gap && last_req_cyc >= 0) checkOutput("gap", cyc - last_req_cyc, 2);
`ifdef FETCH_HALT_DETECT_EN
        checkOutput("halt_noreq", halted, 0);
`endif
      end
      last_req_cyc = cyc;
    end else if (mem_req && busy) begin
      checkOutput("addr_stable", mem_addr, req_addr);
    end
    if (busy && mem_req) begin
      if (lat == 0) ack_now = 1;
      else lat--;
    end

    case (redir_mode)
      1:       fire = 1;
      2:       fire = ack_now && instr_valid;
      3:       fire = mem_req && !ack_now;
      default: fire = 0;
    endcase
    if (do_rst) fire = 0;
    fired = fire;

    rst         = do_rst;
    redirect    = fire;
    redirect_pc = fire ? tgt : 16'($urandom);
    instr_ready = (fire && redir_mode == 2) ? 1'b1 : rdy;
    mem_ack     = ack_now | late_ack;
    mem_rdata   = ack_now ? img(req_addr) : $urandom;

    xfer = instr_valid && instr_ready && !fire && !do_rst;
    if (xfer && model_ok) begin
      checkOutput("out_pc", instr_pc, exp_out);
      checkOutput("out_word", InstructionOUT, img(exp_out));
    end
    if (xfer) last_xfer_pc = instr_pc;
    hold_armed = instr_valid && !instr_ready && !fire && !do_rst;
    hold_pc    = instr_pc;
    hold_word  = InstructionOUT;

    if (do_rst) begin
      model_ok = 1; exp_req = RESET_PC; exp_out = RESET_PC;
      buffered = 0; busy = 0; tainted = 0; halted = 0; hold_armed = 0;
    end else begin
      if (xfer) begin
        exp_out++;
        buffered--;
      end
      if (ack_now) begin
        busy = 0;
        if (!tainted && !fire) begin
          buffered++;
          exp_req++;
          w = img(req_addr);
          if (w[31:27] == 5'b11111) halted = 1;
        end
        tainted = 0;
      end
      if (fire) begin
        exp_req = tgt; exp_out = tgt; buffered = 0; halted = 0;
        if (busy) tainted = 1;
      end
    end
  endtask

  task automatic waitReq(input string tag, input logic [15:0] exp_addr, input bit rdy);
    int n = 0;
    do begin
      applyStimulus(0, rdy, 0, 16'h0, 0);
      n++;
    end while (!new_req_seen && n < 50);
    checkOutput({tag, "_seen"}, new_req_seen, 1);
    checkOutput(tag, mem_addr, exp_addr);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 16'h0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen5;
    int reqs_after, r, n;

    // Reset values and single-cycle memory streaming
    lat_min = 0; lat_max = 0;
    doReset();
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_addr", mem_addr, RESET_PC);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_instr", InstructionOUT, 32'h0);
    checkOutput("rst_pc", instr_pc, 16'h0);
    check_gap = 1; last_req_cyc = -1;
    waitReq("t1_first", 16'h0000, 1);
    repeat (20) applyStimulus(0, 1, 0, 16'h0, 0);
    check_gap = 0;

    // Stall fills the FIFO, then resumes at pc 2
    doReset();
    repeat (10) applyStimulus(0, 0, 0, 16'h0, 0);
    checkOutput("t2_req_off", mem_req, 0);
    checkOutput("t2_valid", instr_valid, 1);
    checkOutput("t2_head_pc", instr_pc, 16'h0);
    waitReq("t2_resume", 16'h0002, 1);
    checkOutput("t2_last_out", last_xfer_pc, 16'h0001);
    repeat (10) applyStimulus(0, 1, 0, 16'h0, 0);

    // Redirect during a slow fetch drops the returning word
    lat_min = 3; lat_max = 3;
    doReset();
    waitReq("t3_req0", 16'h0000, 1);
    applyStimulus(0, 1, 3, 16'h0040, 0);
    checkOutput("t3_fired", fired, 1);
    waitReq("t3_addr", 16'h0040, 0);
    n = 0;
    do begin
      applyStimulus(0, 0, 0, 16'h0, 0);
      n++;
    end while (!instr_valid && n < 20);
    checkOutput("t3_first_pc", instr_pc, 16'h0040);

    // Redirect coinciding with ack and a pop
    lat_min = 0; lat_max = 2;
    doReset();
    n = 0;
    do begin
      applyStimulus(0, $urandom_range(1, 0) == 1, 2, 16'h0123, 0);
      n++;
    end while (!fired && n < 300);
    checkOutput("t4_fired", fired, 1);
    applyStimulus(0, 0, 0, 16'h0, 0);
    checkOutput("t4_empty", instr_valid, 0);
    checkOutput("t4_idle", mem_req, 0);
    waitReq("t4_next", 16'h0123, 1);

    // PC wrap, then reset in the middle of a fetch with a late ack
    lat_min = 0; lat_max = 0;
    doReset();
    applyStimulus(0, 1, 1, 16'hFFFF, 0);
    waitReq("t5_ffff", 16'hFFFF, 1);
    waitReq("t5_wrap", 16'h0000, 1);
    lat_min = 3; lat_max = 3;
    waitReq("t5_wait_req", 16'h0001, 1);
    applyStimulus(1, 1, 0, 16'h0, 0);
    applyStimulus(0, 1, 0, 16'h0, 1);
    checkOutput("t5_req_rst", mem_req, 0);
    checkOutput("t5_addr_rst", mem_addr, RESET_PC);
    checkOutput("t5_valid_rst", instr_valid, 0);
    applyStimulus(0, 1, 0, 16'h0, 0);
    checkOutput("t5_late_ignored", instr_valid, 0);
    checkOutput("t5_restart_req", mem_req, 1);
    checkOutput("t5_restart_addr", mem_addr, RESET_PC);

`ifdef FETCH_HALT_DETECT_EN
    // HALT word at address 5 stops fetching until a redirect
    lat_min = 0; lat_max = 0;
    doReset();
    seen5 = 0; reqs_after = 0;
    repeat (40) begin
      applyStimulus(0, 1, 0, 16'h0, 0);
      if (new_req_seen) begin
        if (seen5) reqs_after++;
        if (mem_addr == 16'd5) seen5 = 1;
      end
    end
    checkOutput("t6_seen5", seen5, 1);
    checkOutput("t6_reqs_after", reqs_after, 0);
    checkOutput("t6_delivered", last_xfer_pc, 16'd5);
    applyStimulus(0, 1, 1, 16'h0010, 0);
    waitReq("t6_restart", 16'h0010, 1);
`endif

    // Randomized mix of latency, stalls, redirects and resets
    lat_min = 0; lat_max = 3;
    doReset();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(99, 0));
      applyStimulus(r < 1, $urandom_range(9, 0) < 7, (r >= 1 && r < 5) ? 1 : 0,
                    ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
